// File: rtl/pacings_monitor_pkg.sv
// Shared types and constants for the pacings monitor.
// Stream indices map result_0..result_11 onto streams a..l.
package pacings_monitor_pkg;

  localparam int DATA_W      = 32;
  localparam int PERIOD_FAST = 10000;
  localparam int PERIOD_SLOW = 20000;
  localparam int NUM_STREAMS = 12;

  typedef logic signed [DATA_W-1:0] value_t;

  typedef struct packed {
    value_t val;
    logic   vld;
  } sample_t;

  localparam int IDX_A = 0;
  localparam int IDX_B = 1;
  localparam int IDX_C = 2;
  localparam int IDX_D = 3;
  localparam int IDX_E = 4;
  localparam int IDX_F = 5;
  localparam int IDX_G = 6;
  localparam int IDX_H = 7;
  localparam int IDX_I = 8;
  localparam int IDX_J = 9;
  localparam int IDX_K = 10;
  localparam int IDX_L = 11;

endpackage

// File: rtl/pacings_monitor_if.sv
// Monitor stimulus/result bundle: master drives samples and enable, slave returns results.
interface pacings_monitor_if;
  import pacings_monitor_pkg::*;

  logic   en;
  value_t x1, x2, x3;
  logic   hasX1, hasX2, hasX3;
  value_t result_0, result_1, result_2, result_3, result_4, result_5;
  value_t result_6, result_7, result_8, result_9, result_10, result_11;

  modport master (
    output en, x1, x2, x3, hasX1, hasX2, hasX3,
    input  result_0, result_1, result_2, result_3, result_4, result_5,
           result_6, result_7, result_8, result_9, result_10, result_11
  );

  modport slave (
    input  en, x1, x2, x3, hasX1, hasX2, hasX3,
    output result_0, result_1, result_2, result_3, result_4, result_5,
           result_6, result_7, result_8, result_9, result_10, result_11
  );

endinterface

// File: rtl/pacing_timer.sv
// Free-running en-cycle counter 0..PERIOD-1; tick is high during the terminal cycle.
module pacing_timer #(
  parameter int PERIOD = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pacings_monitor.sv
// Runtime monitor: nine event-paced and three periodic streams over three input samples.
// Two-stage pipeline (capture, align) feeds the result registers; en stalls every stage.
module pacings_monitor
  import pacings_monitor_pkg::*;
(
  input logic clk,
  input logic rst,
  pacings_monitor_if.slave bus
);

  logic          tick_f, tick_s;
  sample_t [2:0] s1, s2;
  logic          s1_tf, s1_ts, s2_tf, s2_ts;
  value_t        hold [3];
  value_t        held [3];
  value_t        res  [NUM_STREAMS];

  pacing_timer #(.PERIOD(PERIOD_FAST)) u_tf (.clk(clk), .rst(rst), .en(bus.en), .tick(tick_f));
  pacing_timer #(.PERIOD(PERIOD_SLOW)) u_ts (.clk(clk), .rst(rst), .en(bus.en), .tick(tick_s));

  // A fresh sample overrides the held copy in the cycle it is evaluated.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      held[n] = s2[n].vld ? s2[n].val : hold[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      s1_tf <= 1'b0;
      s1_ts <= 1'b0;
      s2_tf <= 1'b0;
      s2_ts <= 1'b0;
      for (int n = 0; n < 3; n++) hold[n] <= '0;
      for (int n = 0; n < NUM_STREAMS; n++) res[n] <= '0;
    end else if (bus.en) begin
      s1[0] <= '{val: bus.x1, vld: bus.hasX1};
      s1[1] <= '{val: bus.x2, vld: bus.hasX2};
      s1[2] <= '{val: bus.x3, vld: bus.hasX3};
      s1_tf <= tick_f;
      s1_ts <= tick_s;
      s2    <= s1;
      s2_tf <= s1_tf;
      s2_ts <= s1_ts;

      for (int n = 0; n < 3; n++) begin
        if (s2[n].vld) hold[n] <= s2[n].val;
      end

      if (s2[0].vld) res[IDX_A] <= s2[0].val;
      if (s2[1].vld) res[IDX_B] <= s2[1].val;
      if (s2[2].vld) res[IDX_C] <= s2[2].val;
      if (s2[0].vld && s2[1].vld) res[IDX_D] <= s2[0].val + s2[1].val;
      if (s2[0].vld && s2[2].vld) res[IDX_E] <= s2[0].val + s2[2].val;
      if (s2[1].vld && s2[2].vld) res[IDX_F] <= s2[1].val + s2[2].val;
      if (s2[0].vld && s2[1].vld && s2[2].vld)
        res[IDX_G] <= s2[0].val + s2[1].val + s2[2].val;
      if (s2[0].vld || s2[1].vld) res[IDX_H] <= held[0] + held[1];
      if (s2[0].vld || s2[1].vld || s2[2].vld) res[IDX_I] <= res[IDX_I] + value_t'(1);

      if (s2_tf) begin
        res[IDX_J] <= res[IDX_J] + value_t'(1);
        res[IDX_K] <= held[0];
      end
      if (s2_ts) res[IDX_L] <= held[1] + held[2];
    end
  end

  assign bus.result_0  = res[IDX_A];
  assign bus.result_1  = res[IDX_B];
  assign bus.result_2  = res[IDX_C];
  assign bus.result_3  = res[IDX_D];
  assign bus.result_4  = res[IDX_E];
  assign bus.result_5  = res[IDX_F];
  assign bus.result_6  = res[IDX_G];
  assign bus.result_7  = res[IDX_H];
  assign bus.result_8  = res[IDX_I];
  assign bus.result_9  = res[IDX_J];
  assign bus.result_10 = res[IDX_K];
  assign bus.result_11 = res[IDX_L];

endmodule

// File: tb/tb_pacings_monitor.sv
// Bench for pacings_monitor: an untimed reference model pushes a snapshot per en-cycle
// into a queue that is popped two en-edges later, when the DUT should show the same values.
module tb_pacings_monitor;
  import pacings_monitor_pkg::*;

  typedef logic [NUM_STREAMS-1:0][DATA_W-1:0] snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pacings_monitor_if bus ();
  pacings_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  snap_t res;
  assign res = {bus.result_11, bus.result_10, bus.result_9, bus.result_8,
                bus.result_7, bus.result_6, bus.result_5, bus.result_4,
                bus.result_3, bus.result_2, bus.result_1, bus.result_0};

  snap_t  m, cur_exp;
  snap_t  sb [$];
  value_t mh [3];
  int     tf_cnt, ts_cnt, en_edges, total_edges;
  int     tests = 0;
  int     failed = 0;

  task automatic model_reset();
    m = '0;
    for (int n = 0; n < 3; n++) mh[n] = '0;
    tf_cnt = 0;
    ts_cnt = 0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    cur_exp = '0;
    en_edges = 0;
    total_edges = 0;
  endtask

  task automatic cycle(input logic e, input logic [2:0] hv, input value_t v1, v2, v3);
    value_t h1, h2, h3;
    logic   tkf, tks;
    bus.en = e; bus.hasX1 = hv[0]; bus.hasX2 = hv[1]; bus.hasX3 = hv[2];
    bus.x1 = v1; bus.x2 = v2; bus.x3 = v3;
    if (e) begin
      h1 = hv[0] ? v1 : mh[0];
      h2 = hv[1] ? v2 : mh[1];
      h3 = hv[2] ? v3 : mh[2];
      tkf = (tf_cnt == PERIOD_FAST - 1);
      tks = (ts_cnt == PERIOD_SLOW - 1);
      tf_cnt = tkf ? 0 : tf_cnt + 1;
      ts_cnt = tks ? 0 : ts_cnt + 1;
      if (hv[0]) m[IDX_A] = v1;
      if (hv[1]) m[IDX_B] = v2;
      if (hv[2]) m[IDX_C] = v3;
      if (hv[0] && hv[1]) m[IDX_D] = v1 + v2;
      if (hv[0] && hv[2]) m[IDX_E] = v1 + v3;
      if (hv[1] && hv[2]) m[IDX_F] = v2 + v3;
      if (&hv) m[IDX_G] = v1 + v2 + v3;
      if (hv[0] || hv[1]) m[IDX_H] = h1 + h2;
      if (|hv) m[IDX_I] = m[IDX_I] + 32'd1;
      if (tkf) begin
        m[IDX_J] = m[IDX_J] + 32'd1;
        m[IDX_K] = h1;
      end
      if (tks) m[IDX_L] = h2 + h3;
      mh[0] = h1; mh[1] = h2; mh[2] = h3;
    end
    @(posedge clk); #1;
    total_edges++;
    if (e) begin
      en_edges++;
      sb.push_back(m);
      cur_exp = sb.pop_front();
    end
  endtask

  task automatic pulse(input logic [2:0] hv, input value_t v1, v2, v3);
    cycle(1'b1, hv, v1, v2, v3);
    cycle(1'b1, 3'b000, '0, '0, '0);
    cycle(1'b1, 3'b000, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.hasX1 = 1'b0; bus.hasX2 = 1'b0; bus.hasX3 = 1'b0;
    bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tests++;
    if (res !== '0) begin
      failed++; $display("FAIL reset_state: got %h, expected all zero", res);
    end
    repeat (100) cycle(1'b1, 3'b000, '0, '0, '0);
    tests++;
    if (res !== '0) begin
      failed++; $display("FAIL reset_idle: got %h, expected all zero", res);
    end
  endtask

  task automatic test_single_streams();
    pulse(3'b011, 1, 2, 0);
    for (int i = 0; i < NUM_STREAMS; i++) begin
      tests++;
      if (res[i] !== cur_exp[i]) begin
        failed++; $display("FAIL pulse12_sb[%0d]: got %0d, expected %0d", i, $signed(res[i]), $signed(cur_exp[i]));
      end
    end
    tests++;
    if (res[IDX_A] !== 1 || res[IDX_B] !== 2 || res[IDX_D] !== 3 || res[IDX_H] !== 3 || res[IDX_I] !== 1) begin
      failed++; $display("FAIL pulse12_abdhi: got a=%0d b=%0d d=%0d h=%0d i=%0d, expected 1 2 3 3 1",
                         res[IDX_A], res[IDX_B], res[IDX_D], res[IDX_H], res[IDX_I]);
    end
    tests++;
    if (res[IDX_C] !== 0 || res[IDX_E] !== 0 || res[IDX_F] !== 0 || res[IDX_G] !== 0) begin
      failed++; $display("FAIL pulse12_cefg: got c=%0d e=%0d f=%0d g=%0d, expected 0", res[IDX_C], res[IDX_E], res[IDX_F], res[IDX_G]);
    end
    pulse(3'b001, 4, 0, 0);
    tests++;
    if (res[IDX_A] !== 4 || res[IDX_H] !== 6 || res[IDX_D] !== 3) begin
      failed++; $display("FAIL pulse_x1: got a=%0d h=%0d d=%0d, expected 4 6 3", res[IDX_A], res[IDX_H], res[IDX_D]);
    end
    pulse(3'b010, 0, 5, 0);
    tests++;
    if (res[IDX_B] !== 5 || res[IDX_H] !== 9) begin
      failed++; $display("FAIL pulse_x2: got b=%0d h=%0d, expected 5 9", res[IDX_B], res[IDX_H]);
    end
    pulse(3'b100, 0, 0, 1);
    tests++;
    if (res[IDX_C] !== 1 || res[IDX_H] !== 9 || res[IDX_I] !== 4) begin
      failed++; $display("FAIL pulse_x3: got c=%0d h=%0d i=%0d, expected 1 9 4", res[IDX_C], res[IDX_H], res[IDX_I]);
    end
    tests++;
    if (res !== cur_exp) begin
      failed++; $display("FAIL single_sb: got %h, expected %h", res, cur_exp);
    end
  endtask

  task automatic test_back_to_back();
    pulse(3'b111, 10, 10, 10);
    tests++;
    if (res[IDX_A] !== 10 || res[IDX_B] !== 10 || res[IDX_C] !== 10 || res[IDX_D] !== 20 ||
        res[IDX_E] !== 20 || res[IDX_F] !== 20 || res[IDX_G] !== 30 || res[IDX_H] !== 20) begin
      failed++; $display("FAIL all10: got %h, expected a..c=10 d..f=20 g=30 h=20", res);
    end
    // consecutive events with no idle gap between them
    cycle(1'b1, 3'b001, 7, 0, 0);
    cycle(1'b1, 3'b111, 100, 100, 100);
    cycle(1'b1, 3'b000, '0, '0, '0);
    cycle(1'b1, 3'b000, '0, '0, '0);
    tests++;
    if (res[IDX_G] !== 300 || res[IDX_H] !== 200 || res[IDX_I] !== 7) begin
      failed++; $display("FAIL all100: got g=%0d h=%0d i=%0d, expected 300 200 7", res[IDX_G], res[IDX_H], res[IDX_I]);
    end
    for (int i = 0; i < NUM_STREAMS; i++) begin
      tests++;
      if (res[i] !== cur_exp[i]) begin
        failed++; $display("FAIL b2b_sb[%0d]: got %0d, expected %0d", i, $signed(res[i]), $signed(cur_exp[i]));
      end
    end
  endtask

  task automatic test_periodic();
    snap_t frozen;
    int    n = 0;
    while (res[IDX_J] == 0 && n < PERIOD_FAST + 10) begin
      cycle(1'b1, 3'b000, '0, '0, '0);
      n++;
    end
    tests++;
    if (en_edges != PERIOD_FAST + 2) begin
      failed++; $display("FAIL tick_fast_time: got j change at en-edge %0d, expected %0d", en_edges, PERIOD_FAST + 2);
    end
    tests++;
    if (res[IDX_J] !== 1 || res[IDX_K] !== 100) begin
      failed++; $display("FAIL tick_fast_jk: got j=%0d k=%0d, expected 1 100", res[IDX_J], res[IDX_K]);
    end
    frozen = res;
    repeat (500) cycle(1'b0, 3'b111, 55, 66, 77);
    tests++;
    if (res !== frozen) begin
      failed++; $display("FAIL en_freeze: got %h, expected %h", res, frozen);
    end
    n = 0;
    while (res[IDX_J] == 1 && n < PERIOD_FAST + 10) begin
      cycle(1'b1, 3'b000, '0, '0, '0);
      n++;
    end
    tests++;
    if (en_edges != 2 * PERIOD_FAST + 2 || total_edges != 2 * PERIOD_FAST + 502) begin
      failed++; $display("FAIL tick_slow_time: got en-edge %0d total %0d, expected %0d %0d",
                         en_edges, total_edges, 2 * PERIOD_FAST + 2, 2 * PERIOD_FAST + 502);
    end
    tests++;
    if (res[IDX_J] !== 2 || res[IDX_L] !== 200) begin
      failed++; $display("FAIL tick_slow_jl: got j=%0d l=%0d, expected 2 200", res[IDX_J], res[IDX_L]);
    end
    tests++;
    if (res !== cur_exp) begin
      failed++; $display("FAIL periodic_sb: got %h, expected %h", res, cur_exp);
    end
  endtask

  task automatic test_wrap();
    pulse(3'b011, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0);
    tests++;
    if (res[IDX_D] !== 32'hFFFF_FFFE || res[IDX_H] !== 32'hFFFF_FFFE) begin
      failed++; $display("FAIL wrap_d: got d=%0d h=%0d, expected -2 -2", $signed(res[IDX_D]), $signed(res[IDX_H]));
    end
    tests++;
    if (res !== cur_exp) begin
      failed++; $display("FAIL wrap_sb: got %h, expected %h", res, cur_exp);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 3'b111, 5, 6, 7);
    rst = 1'b1;
    bus.hasX1 = 1'b0; bus.hasX2 = 1'b0; bus.hasX3 = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (res !== '0) begin
      failed++; $display("FAIL midrst_now: got %h, expected all zero", res);
    end
    rst = 1'b0;
    model_reset();
    repeat (4) cycle(1'b1, 3'b000, '0, '0, '0);
    tests++;
    if (res !== '0) begin
      failed++; $display("FAIL midrst_flush: got %h, expected all zero", res);
    end
    tests++;
    if (res !== cur_exp) begin
      failed++; $display("FAIL midrst_sb: got %h, expected %h", res, cur_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_streams();
    test_back_to_back();
    test_periodic();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
